// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS lane scheduler: control tokens, symbol and pixel field layout.
package tmds_pkg;

    localparam int SYM_W = 10;
    localparam int PIX_W = 24;
    localparam int B_LSB = 0;
    localparam int G_LSB = 8;
    localparam int R_LSB = 16;

    // Indexed by {c1, c0}
    localparam logic [SYM_W-1:0] CTRL_TOKEN [0:3] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_encoder.sv
// One TMDS lane: 8b/10b data encoding with running disparity, or a control token during blanking.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             ctrl_mode_i,
    input  logic [7:0]       data_i,
    input  logic [1:0]       ctrl_i,
    output logic [SYM_W-1:0] symbol_o
);

    logic [SYM_W-1:0] symbol_q, symbol_d;
    logic signed [4:0] disp_q, disp_d;
    logic signed [5:0] disp_ext, disp_w, diff;
    logic [8:0] q_m;
    logic [3:0] n1d, n1q;
    logic       use_xnor;

    always_comb begin
        n1d      = ones8(data_i);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_i[0]);
        q_m      = '0;
        q_m[0]   = data_i[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ data_i[i]) : (q_m[i-1] ^ data_i[i]);
        end
        q_m[8]   = ~use_xnor;
        n1q      = ones8(q_m[7:0]);
        // Ones minus zeros of the 8 data bits of q_m, range -8..+8
        diff     = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
        disp_ext = {disp_q[4], disp_q};
        disp_w   = disp_ext;
        symbol_d = symbol_q;
        disp_d   = disp_q;
        if (ctrl_mode_i) begin
            symbol_d = CTRL_TOKEN[ctrl_i];
            disp_d   = '0;
        end else begin
            if ((disp_q == 5'sd0) || (diff == 6'sd0)) begin
                symbol_d = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
                disp_w   = q_m[8] ? (disp_ext + diff) : (disp_ext - diff);
            end else if (((disp_q > 5'sd0) && (diff > 6'sd0)) ||
                         ((disp_q < 5'sd0) && (diff < 6'sd0))) begin
                symbol_d = {1'b1, q_m[8], ~q_m[7:0]};
                disp_w   = disp_ext + (q_m[8] ? 6'sd2 : 6'sd0) - diff;
            end else begin
                symbol_d = {1'b0, q_m[8], q_m[7:0]};
                disp_w   = disp_ext - (q_m[8] ? 6'sd0 : 6'sd2) + diff;
            end
            disp_d = disp_w[4:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            symbol_q <= '0;
            disp_q   <= '0;
        end else if (load_i) begin
            symbol_q <= symbol_d;
            disp_q   <= disp_d;
        end
    end

    assign symbol_o = symbol_q;

endmodule

// File: rtl/tmds_frame_scheduler.sv
// Raster timing plus a one-entry output stage that broadcasts one symbol triple to the three lane FIFOs,
// stalling all lanes together while any lane FIFO is full.
module tmds_frame_scheduler
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 12
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [PIX_W-1:0] pixel_i,
    input  logic             pixel_valid_i,
    output logic             pixel_ready_o,
    input  logic [2:0]       fifo_full_i,
    output logic             write_symbol_o,
    output logic [SYM_W-1:0] symbol0_o,
    output logic [SYM_W-1:0] symbol1_o,
    output logic [SYM_W-1:0] symbol2_o,
    output logic             frame_start_o,
    output logic             underflow_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);

    logic [CW-1:0]    h_q, h_d, v_q, v_d;
    logic             valid_q, frame_start_q, underflow_q;
    logic             fire, load, active, hsync, vsync;
    logic [PIX_W-1:0] pix;

    // Reset gates the handshake so nothing leaks out while the stage is being flushed
    assign fire   = valid_q & ~|fifo_full_i & ~reset_i;
    assign load   = (~valid_q | fire) & ~reset_i;
    assign active = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign hsync  = ((h_q >= HS_BEG_C) && (h_q < HS_END_C)) ? HSYNC_POL : ~HSYNC_POL;
    assign vsync  = ((v_q >= VS_BEG_C) && (v_q < VS_END_C)) ? VSYNC_POL : ~VSYNC_POL;
    assign pix    = pixel_valid_i ? pixel_i : '0;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (load) begin
            if (h_q == H_LAST_C) begin
                h_d = '0;
                v_d = (v_q == V_LAST_C) ? '0 : v_q + ONE_C;
            end else begin
                h_d = h_q + ONE_C;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_q           <= '0;
            v_q           <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            if (load) begin
                valid_q       <= 1'b1;
                frame_start_q <= (h_q == '0) && (v_q == '0);
            end
            if (load && active && !pixel_valid_i) begin
                underflow_q <= 1'b1;
            end
        end
    end

    tmds_encoder u_lane0 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load),
        .ctrl_mode_i (~active),
        .data_i      (pix[B_LSB +: 8]),
        .ctrl_i      ({vsync, hsync}),
        .symbol_o    (symbol0_o)
    );

    tmds_encoder u_lane1 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load),
        .ctrl_mode_i (~active),
        .data_i      (pix[G_LSB +: 8]),
        .ctrl_i      (2'b00),
        .symbol_o    (symbol1_o)
    );

    tmds_encoder u_lane2 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load),
        .ctrl_mode_i (~active),
        .data_i      (pix[R_LSB +: 8]),
        .ctrl_i      (2'b00),
        .symbol_o    (symbol2_o)
    );

    assign pixel_ready_o  = load & active;
    assign write_symbol_o = fire;
    assign frame_start_o  = fire & frame_start_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_tmds_frame_scheduler.sv
// Bench for the TMDS frame scheduler on an 8x5 raster: raster-position model plus directed stall/underflow/reset cases.
module tb_tmds_frame_scheduler;

    localparam int HT = 8;
    localparam int VT = 5;
    localparam int HA = 4;
    localparam int VA = 2;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [23:0] pixel_i = 24'h0;
    logic        pixel_valid_i = 1'b1;
    logic        pixel_ready_o;
    logic [2:0]  fifo_full_i = 3'b000;
    logic        write_symbol_o;
    logic [9:0]  symbol0_o, symbol1_o, symbol2_o;
    logic        frame_start_o;
    logic        underflow_o;

    int checks = 0;
    int errors = 0;

    tmds_frame_scheduler #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(12)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .pixel_i        (pixel_i),
        .pixel_valid_i  (pixel_valid_i),
        .pixel_ready_o  (pixel_ready_o),
        .fifo_full_i    (fifo_full_i),
        .write_symbol_o (write_symbol_o),
        .symbol0_o      (symbol0_o),
        .symbol1_o      (symbol1_o),
        .symbol2_o      (symbol2_o),
        .frame_start_o  (frame_start_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] mem [0:63];
    int          pix_n = 0;
    logic        adv = 1'b0;
    logic [23:0] qpix [$];
    int          disp_m [0:2];
    int          pos = 0;
    int          cyc = 0;
    logic        last_wr = 1'b0;
    int          last_pos = 0;

    function automatic logic [9:0] enc(input logic [7:0] d, input int lane);
        logic [8:0] qm;
        logic       xn;
        int         n1, ones, zeros, cnt;
        logic [9:0] s;
        n1    = $countones(d);
        xn    = (n1 > 4) || (n1 == 4 && !d[0]);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        ones  = $countones(qm[7:0]);
        zeros = 8 - ones;
        cnt   = disp_m[lane];
        if (cnt == 0 || ones == zeros) begin
            s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            cnt = cnt + (qm[8] ? (ones - zeros) : (zeros - ones));
        end else if ((cnt > 0 && ones > zeros) || (cnt < 0 && zeros > ones)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            cnt = cnt + (qm[8] ? 2 : 0) + zeros - ones;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            cnt = cnt - (qm[8] ? 0 : 2) + ones - zeros;
        end
        disp_m[lane] = cnt;
        return s;
    endfunction

    function automatic logic [9:0] token(input int h, input int v);
        logic hs, vs;
        hs = !(h >= 5 && h < 7);
        vs = !(v == 3);
        case ({vs, hs})
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [9:0]  e0, e1, e2;
        logic [23:0] p;
        int h, v;
        adv = 1'b0;
        if (reset_i) begin
            cyc = 0;
            pos = 0;
            qpix.delete();
            for (int l = 0; l < 3; l++) disp_m[l] = 0;
            last_wr = 1'b0;
            chk("rst_write", 32'(write_symbol_o), 32'd0);
            chk("rst_ready", 32'(pixel_ready_o), 32'd0);
            chk("rst_fstart", 32'(frame_start_o), 32'd0);
        end else begin
            if (cyc < 1000) cyc++;
            chk("write_strobe", 32'(write_symbol_o), 32'((cyc >= 2) && (fifo_full_i == 3'b000)));
            last_wr = write_symbol_o;
            if (write_symbol_o) begin
                h = pos % HT;
                v = pos / HT;
                if (h < HA && v < VA) begin
                    if (qpix.size() == 0) begin
                        p = 24'h0;
                        errors++;
                        checks++;
                        $display("FAIL pix_queue actual=empty expected=pixel pos=%0d", pos);
                    end else begin
                        p = qpix.pop_front();
                    end
                    e0 = enc(p[7:0], 0);
                    e1 = enc(p[15:8], 1);
                    e2 = enc(p[23:16], 2);
                end else begin
                    e0 = token(h, v);
                    e1 = 10'h354;
                    e2 = 10'h354;
                    for (int l = 0; l < 3; l++) disp_m[l] = 0;
                end
                chk("sym0", 32'(symbol0_o), 32'(e0));
                chk("sym1", 32'(symbol1_o), 32'(e1));
                chk("sym2", 32'(symbol2_o), 32'(e2));
                chk("frame_start", 32'(frame_start_o), 32'(pos == 0));
                last_pos = pos;
                pos = (pos + 1) % FRAME;
            end else begin
                chk("fstart_idle", 32'(frame_start_o), 32'd0);
            end
            if (pixel_ready_o) begin
                qpix.push_back(pixel_valid_i ? pixel_i : 24'h0);
                adv = pixel_valid_i;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (adv) begin
            pix_n++;
            pixel_i = mem[pix_n % 64];
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (last_wr && last_pos == p) return;
        end
        chk("wait_pos_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_pos(input int p, input logic [9:0] x0, input logic [9:0] x1, input logic [9:0] x2);
        wait_pos(p);
        chk($sformatf("lit_pos%0d_l0", p), 32'(symbol0_o), 32'(x0));
        chk($sformatf("lit_pos%0d_l1", p), 32'(symbol1_o), 32'(x1));
        chk($sformatf("lit_pos%0d_l2", p), 32'(symbol2_o), 32'(x2));
    endtask

    initial begin
        logic [9:0] s0, s1, s2;
        for (int i = 0; i < 64; i++) mem[i] = {8'(i * 53 + 7), 8'(i * 29 + 100), 8'(i * 71 + 3)};
        mem[0] = 24'hFFFFFF;
        mem[4] = 24'h000000;
        pixel_i = mem[0];

        // 1: reset and first-write latency
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk); #1;
        chk("lat_cycle1_write", 32'(write_symbol_o), 32'd0);
        @(negedge clk); #1;
        chk("lat_cycle2_write", 32'(write_symbol_o), 32'd1);
        chk("lat_cycle2_fstart", 32'(frame_start_o), 32'd1);
        chk("lit_white_l0", 32'(symbol0_o), 32'h200);
        chk("lit_white_l1", 32'(symbol1_o), 32'h200);
        chk("lit_white_l2", 32'(symbol2_o), 32'h200);

        // 3 and 2: blanking tokens on line 0, black on first px of line 1
        check_pos(4, 10'h2AB, 10'h354, 10'h354);
        check_pos(5, 10'h154, 10'h354, 10'h354);
        check_pos(6, 10'h154, 10'h354, 10'h354);
        check_pos(7, 10'h2AB, 10'h354, 10'h354);
        check_pos(8, 10'h100, 10'h100, 10'h100);
        wait_pos(0);
        chk("frame2_fstart", 32'(frame_start_o), 32'd1);

        // 4: stall mid-active
        wait_pos(9);
        step();
        fifo_full_i = 3'b010;
        s0 = symbol0_o; s1 = symbol1_o; s2 = symbol2_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("stall_write", 32'(write_symbol_o), 32'd0);
            chk("stall_ready", 32'(pixel_ready_o), 32'd0);
            chk("stall_sym0", 32'(symbol0_o), 32'(s0));
            chk("stall_sym1", 32'(symbol1_o), 32'(s1));
            chk("stall_sym2", 32'(symbol2_o), 32'(s2));
        end
        step();
        fifo_full_i = 3'b000;
        wait_pos(0);

        // 5: one underflow slot (load of pos 2)
        chk("uf_before", 32'(underflow_o), 32'd0);
        step();
        pixel_valid_i = 1'b0;
        step();
        pixel_valid_i = 1'b1;
        step();
        chk("uf_set", 32'(underflow_o), 32'd1);
        wait_pos(0);
        chk("uf_frame_start", 32'(frame_start_o), 32'd1);
        chk("uf_sticky", 32'(underflow_o), 32'd1);

        // 6: reset while a symbol for (3,1) is held
        wait_pos(10);
        step();
        fifo_full_i = 3'b111;
        @(negedge clk); #1;
        chk("held_write", 32'(write_symbol_o), 32'd0);
        step();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        fifo_full_i = 3'b000;
        @(negedge clk); #1;
        chk("rst2_cycle1_write", 32'(write_symbol_o), 32'd0);
        chk("rst2_uf_clear", 32'(underflow_o), 32'd0);
        chk("rst2_sym_clear", 32'(symbol0_o), 32'd0);
        @(negedge clk); #1;
        chk("rst2_cycle2_write", 32'(write_symbol_o), 32'd1);
        chk("rst2_fstart", 32'(frame_start_o), 32'd1);
        wait_pos(FRAME - 1);
        wait_pos(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
